// File: rtl/char_seq.sv
// Character sequencer: a FIFO of host ASCII bytes shown one at a time for DWELL cycles each.
// Define CHAR_SEQ_GAP_EN to insert a GAP-cycle blank after every character.
module char_seq #(
  parameter int DEPTH = 16,
  parameter int DWELL = 12000000,
  parameter int GAP   = 1200000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [7:0]               wr_data,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic                     flush,
  output logic [7:0]               disp_char,
  output logic                     disp_active,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW   = $clog2(DEPTH);
  localparam int LW   = AW + 1;
  localparam int MAXC = (DWELL > GAP) ? DWELL : GAP;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam logic [CW-1:0] DWELL_LD = CW'(DWELL - 1);
`ifdef CHAR_SEQ_GAP_EN
  localparam logic [CW-1:0] GAP_LD   = CW'(GAP - 1);
`endif
  localparam logic [LW-1:0] FULL     = LW'(DEPTH);
  localparam logic [7:0]    BLANK    = 8'h20;
  localparam logic [7:0]    SUBST    = 8'h3F;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SHOW = 2'd1
`ifdef CHAR_SEQ_GAP_EN
    , ST_GAP = 2'd2
`endif
  } state_t;

  state_t          state, state_next;
  logic [CW-1:0]   cnt, cnt_next;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [7:0]      mem [DEPTH];
  logic            push, pop;
  logic [7:0]      popped, shown;
  logic [7:0]      disp_char_next;
  logic            disp_active_next;

  // Full is judged on the registered level, so a pop cannot free a slot for a same-cycle write.
  assign wr_ready = (level != FULL);
  assign push     = wr_valid && wr_ready && !flush;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level       <= '0;
      disp_char   <= BLANK;
      disp_active <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state       <= state_next;
      cnt         <= cnt_next;
      disp_char   <= disp_char_next;
      disp_active <= disp_active_next;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        level  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        case ({push, pop})
          2'b10:   level <= level + LW'(1);
          2'b01:   level <= level - LW'(1);
          default: level <= level;
        endcase
      end
    end
  end

  // NOTE: character storage is deliberately not reset; level and pointers alone define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // Next-state logic
  always_comb begin
    // NOTE: defaults first keep this block free of inferred latches.
    state_next = state;
    cnt_next   = cnt;
    pop        = 1'b0;
    case (state)
      ST_IDLE: begin
        if (level != '0) begin
          pop        = 1'b1;
          state_next = ST_SHOW;
          cnt_next   = DWELL_LD;
        end
      end
      ST_SHOW: begin
        if (cnt != '0) begin
          cnt_next = cnt - CW'(1);
`ifdef CHAR_SEQ_GAP_EN
        end else begin
          state_next = ST_GAP;
          cnt_next   = GAP_LD;
        end
      end
      ST_GAP: begin
        if (cnt != '0) begin
          cnt_next = cnt - CW'(1);
`endif
        end else if (level != '0) begin
          pop        = 1'b1;
          state_next = ST_SHOW;
          cnt_next   = DWELL_LD;
        end else begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
    if (flush) begin
      state_next = ST_IDLE;
      cnt_next   = '0;
      pop        = 1'b0;
    end
  end

  // Output logic: the display registers follow the transition being taken.
  always_comb begin
    popped           = mem[rd_ptr];
    shown            = (popped >= 8'h20 && popped <= 8'h7E) ? popped : SUBST;
    disp_char_next   = disp_char;
    disp_active_next = disp_active;
    if (flush || state_next == ST_IDLE) begin
      disp_char_next   = BLANK;
      disp_active_next = 1'b0;
    end else if (pop) begin
      disp_char_next   = shown;
      disp_active_next = 1'b1;
    end
`ifdef CHAR_SEQ_GAP_EN
    else if (state_next == ST_GAP) begin
      disp_char_next   = BLANK;
      disp_active_next = 1'b0;
    end
`endif
  end

endmodule

// File: tb/tb_char_seq.sv
// Randomised scoreboard bench for char_seq (DEPTH=4, DWELL=4, GAP=2); honours CHAR_SEQ_GAP_EN.
module tb_char_seq;

  localparam int DEPTH = 4;
  localparam int DWELL = 4;
  localparam int GAP   = 2;
`ifdef CHAR_SEQ_GAP_EN
  localparam bit GAP_EN = 1'b1;
`else
  localparam bit GAP_EN = 1'b0;
`endif

  typedef struct {
    logic [7:0] ch;
    logic       act;
    logic [2:0] lvl;
    logic       rdy;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [7:0] wr_data;
  logic       wr_valid;
  logic       wr_ready;
  logic       flush;
  logic [7:0] disp_char;
  logic       disp_active;
  logic [2:0] level;

  int n_checks = 0;
  int n_fail   = 0;

  char_seq #(.DEPTH(DEPTH), .DWELL(DWELL), .GAP(GAP)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_data    (wr_data),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .flush      (flush),
    .disp_char  (disp_char),
    .disp_active(disp_active),
    .level      (level)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] sub(input logic [7:0] c);
    return (c >= 8'h20 && c <= 8'h7E) ? c : 8'h3F;
  endfunction

  // Reference model: a queue of pending bytes and a timeline of display segments.
  logic [7:0] mq[$];
  logic [7:0] char_q[$];
  exp_t       exp_q[$];
  int         m_phase = 0;   // 0 idle, 1 showing, 2 blank gap
  int         m_left  = 0;   // cycles of the current segment still to come, including this one
  logic [7:0] m_cur   = 8'h20;
  bit         m_acc   = 1'b0;

  always @(posedge clk) begin
    bit   start;
    exp_t e;
    m_acc = 1'b0;
    start = 1'b0;
    if (!rst_n || flush) begin
      mq.delete();
      char_q.delete();
      m_phase = 0;
      m_left  = 0;
    end else begin
      m_acc = wr_valid && (mq.size() != DEPTH);
      if (m_phase == 0) begin
        start = (mq.size() > 0);
      end else if (m_left > 1) begin
        m_left--;
      end else if (m_phase == 1 && GAP_EN) begin
        m_phase = 2;
        m_left  = GAP;
      end else if (mq.size() > 0) begin
        start = 1'b1;
      end else begin
        m_phase = 0;
      end
      if (start) begin
        m_cur   = sub(mq.pop_front());
        m_phase = 1;
        m_left  = DWELL;
      end
      if (m_acc) begin
        mq.push_back(wr_data);
        char_q.push_back(sub(wr_data));
      end
    end
    e.ch  = (m_phase == 1) ? m_cur : 8'h20;
    e.act = (m_phase == 1);
    e.lvl = 3'(mq.size());
    e.rdy = (mq.size() != DEPTH);
    exp_q.push_back(e);
  end

  // Monitor: per-cycle outputs against the model, plus order of displayed characters.
  bit prev_act = 1'b0;
  int run_len  = 0;

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("disp_char",   disp_char,   e.ch);
      check("disp_active", disp_active, e.act);
      check("level",       level,       e.lvl);
      check("wr_ready",    wr_ready,    e.rdy);
    end
    if (disp_active === 1'b1) begin
      if (!prev_act || run_len == DWELL) begin
        if (char_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL char_order: got %0h, expected no character (t=%0t)", disp_char, $time);
        end else begin
          check("char_order", disp_char, char_q.pop_front());
        end
        run_len = 1;
      end else begin
        run_len++;
      end
    end else begin
      run_len = 0;
    end
    prev_act = (disp_active === 1'b1);
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic put(input logic [7:0] c);
    int n;
    n        = 0;
    wr_valid = 1'b1;
    wr_data  = c;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!m_acc && n < 100);
    wr_valid = 1'b0;
    check("put_accepted", m_acc, 1);
  endtask

  task automatic put4_until_level3();
    put(8'h61); put(8'h62); put(8'h63); put(8'h64);
  endtask

  initial begin
    rst_n    = 1'b0;
    wr_valid = 1'b0;
    wr_data  = 8'h00;
    flush    = 1'b0;
    idle(3);
    rst_n = 1'b1;
    idle(2);

    put(8'h41);                        // single character
    idle(10);
    put(8'h31); put(8'h32);            // back-to-back pair
    idle(16);
    for (int i = 0; i < 6; i++) put(8'h4B + 8'(i));  // stall the FIFO until full
    idle(34);
    put(8'h07); put(8'h7F);            // non-printable substitution
    idle(16);

    put4_until_level3();               // flush with a colliding write
    wr_valid = 1'b1;
    wr_data  = 8'h7A;
    flush    = 1'b1;
    @(posedge clk);
    #1;
    wr_valid = 1'b0;
    flush    = 1'b0;
    check("flush_level",  level,       0);
    check("flush_char",   disp_char,   8'h20);
    check("flush_active", disp_active, 0);
    idle(8);

    put4_until_level3();               // asynchronous reset mid-show
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_char",   disp_char,   8'h20);
    check("rst_active", disp_active, 0);
    check("rst_level",  level,       0);
    check("rst_ready",  wr_ready,    1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    put(8'h5A);                        // first write right after release
    idle(8);

    for (int i = 0; i < 400; i++) begin
      wr_valid = ($urandom_range(0, 3) != 0);
      wr_data  = 8'($urandom_range(0, 255));
      flush    = ($urandom_range(0, 59) == 0);
      @(posedge clk);
      #1;
    end
    wr_valid = 1'b0;
    flush    = 1'b0;
    idle(40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
